// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the RAM-port arbiter between the CPU datapath and the debug/loader master.
// State encoding, bus-width defaults and the address range helper.
package mem_bus_arbiter_pkg;

  localparam int ARB_ADDR_WIDTH    = 16;
  localparam int ARB_DATA_WIDTH    = 8;
  localparam int ARB_MEM_DEPTH     = 32768;
  localparam int ARB_STALL_TIMEOUT = 64;
  localparam int ARB_LEN_WIDTH     = 8;

  typedef enum logic [2:0] {
    CPU_OWN     = 3'd0,
    STALL_WAIT  = 3'd1,
    DBG_SETUP   = 3'd2,
    DBG_CAPTURE = 3'd3,
    RELEASE     = 3'd4
  } arb_state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: CPU side, debug master side and RAM side.
// The arbiter connects through the slave modport, its environment through master.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0]    cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic                     cpu_oe;
  logic                     cpu_we;
  logic [DATA_WIDTH-1:0]    cpu_rdata;
  logic                     cpu_at_boundary;
  logic                     cpu_stall;
  logic                     dbg_req;
  logic                     dbg_we;
  logic [ADDR_WIDTH-1:0]    dbg_addr;
  logic [ARB_LEN_WIDTH-1:0] dbg_len;
  logic [DATA_WIDTH-1:0]    dbg_wdata;
  logic                     dbg_gnt;
  logic                     dbg_ack;
  logic [DATA_WIDTH-1:0]    dbg_rdata;
  logic                     dbg_err;
  logic                     dbg_done;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_oe;
  logic                     mem_we;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_oe, cpu_we, cpu_at_boundary,
    input  dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, dbg_gnt, dbg_ack, dbg_rdata, dbg_err, dbg_done,
    output mem_addr, mem_wdata, mem_oe, mem_we
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_oe, cpu_we, cpu_at_boundary,
    output dbg_req, dbg_we, dbg_addr, dbg_len, dbg_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, dbg_gnt, dbg_ack, dbg_rdata, dbg_err, dbg_done,
    input  mem_addr, mem_wdata, mem_oe, mem_we
  );

endinterface

// File: rtl/mem_bus_arbiter_burst_ctr.sv
// Burst address incrementer (wraps modulo 2^ADDR_WIDTH) and beat down-counter.
// last is high while the current beat is the final one of the burst.
module arb_burst_ctr #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LEN_WIDTH-1:0]  beats_r;

  // address and remaining-beat registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r  <= {ADDR_WIDTH{1'b0}};
      beats_r <= {LEN_WIDTH{1'b0}};
    end else if (load) begin
      addr_r  <= load_addr;
      beats_r <= load_len;
    end else if (step) begin
      addr_r  <= addr_r + ADDR_WIDTH'(1);
      beats_r <= beats_r - LEN_WIDTH'(1);
    end else begin
      addr_r  <= addr_r;
      beats_r <= beats_r;
    end
  end

  assign addr = addr_r;
  assign last = (beats_r == {LEN_WIDTH{1'b0}});

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the RAM port between the CPU and a debug/loader master doing single/burst accesses.
// Optional macro ARB_STALL_TIMEOUT_EN: abandon the request if no CPU boundary arrives in time.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH    = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH    = ARB_DATA_WIDTH,
  parameter int MEM_DEPTH     = ARB_MEM_DEPTH,
  parameter int STALL_TIMEOUT = ARB_STALL_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus
);

  arb_state_e            state_r;
  arb_state_e            next_state_s;
  logic                  dbg_we_r;
  logic                  block_r;
  logic [DATA_WIDTH-1:0] dbg_rdata_r;
  logic [ADDR_WIDTH-1:0] cnt_addr_s;
  logic                  last_s;
  logic                  load_s;
  logic                  step_s;
  logic                  in_range_s;
  logic                  timeout_hit_s;

  // block_r holds off a new request for the first CPU_OWN cycle after a hand-back
  assign load_s     = (state_r == CPU_OWN) && bus.dbg_req && !block_r;
  assign step_s     = ((state_r == DBG_SETUP) && (dbg_we_r || !in_range_s)) ||
                      (state_r == DBG_CAPTURE);
  assign in_range_s = addr_in_range(32'(cnt_addr_s), 32'(MEM_DEPTH));
  assign bus.cpu_rdata = bus.mem_rdata;

  arb_burst_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (ARB_LEN_WIDTH)
  ) u_burst_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .step      (step_s),
    .load_addr (bus.dbg_addr),
    .load_len  (bus.dbg_len),
    .addr      (cnt_addr_s),
    .last      (last_s)
  );

`ifdef ARB_STALL_TIMEOUT_EN
  localparam int TO_W = $clog2(STALL_TIMEOUT + 1);
  logic [TO_W-1:0] stall_cnt_r;

  // cycles spent waiting for the CPU boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == STALL_WAIT) begin
      stall_cnt_r <= stall_cnt_r + TO_W'(1);
    end else begin
      stall_cnt_r <= {TO_W{1'b0}};
    end
  end

  assign timeout_hit_s = (stall_cnt_r == TO_W'(STALL_TIMEOUT - 1)) && !bus.cpu_at_boundary;
`else
  logic unused_stall_timeout_s;
  assign unused_stall_timeout_s = (STALL_TIMEOUT == 32'sd0);
  assign timeout_hit_s          = 1'b0;
`endif

  // state, burst direction, re-request hold-off and read-data holding register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= CPU_OWN;
      dbg_we_r    <= 1'b0;
      block_r     <= 1'b0;
      dbg_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      block_r <= (state_r == RELEASE) || ((state_r == STALL_WAIT) && timeout_hit_s);
      if (load_s) begin
        dbg_we_r <= bus.dbg_we;
      end else begin
        dbg_we_r <= dbg_we_r;
      end
      if (state_r == DBG_CAPTURE) begin
        dbg_rdata_r <= bus.mem_rdata;
      end else if ((state_r == DBG_SETUP) && !dbg_we_r && !in_range_s) begin
        dbg_rdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
      end
    end
  end

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      CPU_OWN: begin
        if (load_s) next_state_s = STALL_WAIT;
        else        next_state_s = CPU_OWN;
      end
      STALL_WAIT: begin
        if (bus.cpu_at_boundary)  next_state_s = DBG_SETUP;
        else if (timeout_hit_s)   next_state_s = CPU_OWN;
        else                      next_state_s = STALL_WAIT;
      end
      DBG_SETUP: begin
        if (!dbg_we_r && in_range_s) next_state_s = DBG_CAPTURE;
        else if (last_s)             next_state_s = RELEASE;
        else                         next_state_s = DBG_SETUP;
      end
      DBG_CAPTURE: begin
        if (last_s) next_state_s = RELEASE;
        else        next_state_s = DBG_SETUP;
      end
      RELEASE: next_state_s = CPU_OWN;
      default: next_state_s = CPU_OWN;
    endcase
  end

  // bus steering and handshake outputs; CPU strobes pass through until the grant
  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_oe    = bus.cpu_oe;
    bus.mem_we    = bus.cpu_we;
    bus.cpu_stall = 1'b0;
    bus.dbg_gnt   = 1'b0;
    bus.dbg_ack   = 1'b0;
    bus.dbg_err   = 1'b0;
    bus.dbg_done  = 1'b0;
    bus.dbg_rdata = dbg_rdata_r;
    case (state_r)
      CPU_OWN: begin
        bus.cpu_stall = 1'b0;
      end
      STALL_WAIT: begin
        bus.cpu_stall = 1'b1;
        bus.dbg_err   = timeout_hit_s;
      end
      DBG_SETUP: begin
        bus.cpu_stall = 1'b1;
        bus.dbg_gnt   = 1'b1;
        bus.mem_addr  = cnt_addr_s;
        bus.mem_wdata = bus.dbg_wdata;
        bus.mem_oe    = !dbg_we_r && in_range_s;
        bus.mem_we    = dbg_we_r && in_range_s;
        bus.dbg_ack   = dbg_we_r || !in_range_s;
        bus.dbg_err   = !in_range_s;
        if (!dbg_we_r && !in_range_s) bus.dbg_rdata = {DATA_WIDTH{1'b0}};
        else                          bus.dbg_rdata = dbg_rdata_r;
      end
      DBG_CAPTURE: begin
        bus.cpu_stall = 1'b1;
        bus.dbg_gnt   = 1'b1;
        bus.mem_addr  = cnt_addr_s;
        bus.mem_wdata = bus.dbg_wdata;
        bus.mem_oe    = 1'b1;
        bus.mem_we    = 1'b0;
        bus.dbg_ack   = 1'b1;
        bus.dbg_rdata = bus.mem_rdata;
      end
      RELEASE: begin
        bus.mem_addr  = cnt_addr_s;
        bus.mem_wdata = bus.dbg_wdata;
        bus.mem_oe    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.dbg_done  = 1'b1;
      end
      default: begin
        bus.cpu_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a synchronous-read RAM model on the memory side.
// Define ARB_STALL_TIMEOUT_EN to also exercise the stall timeout.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        err;
  } exp_t;

  logic       clk;
  logic       reset;
  int         total;
  int         bad;
  exp_t       sb_q[$];
  logic [7:0] ram    [0:32767];
  logic [7:0] shadow [0:32767];

  mem_bus_arbiter_if bus();

  mem_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read
  always @(posedge clk) begin
    if (bus.mem_we && !bus.mem_addr[15]) ram[bus.mem_addr[14:0]] <= bus.mem_wdata;
    if (bus.mem_oe) bus.mem_rdata <= bus.mem_addr[15] ? 8'h00 : ram[bus.mem_addr[14:0]];
  end

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_we = 1'b1;
    @(posedge clk); #1;
    bus.cpu_we = 1'b0;
    shadow[a[14:0]] = d;
  endtask

  // Drives one debug burst; expectations are queued up front and popped on every dbg_ack.
  task automatic run_burst(input logic we, input logic [15:0] addr, input logic [7:0] len,
                           input logic [7:0] wbase, input logic hold_req,
                           output int acks, output int dones, output int gnt_lat,
                           output int min_gap, output int max_gap);
    exp_t e;
    logic [15:0] a;
    int last_ack;
    logic ack_seen;
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 16'(i);
      e.addr = a;
      e.err  = a[15];
      if (we)        e.data = wbase + 8'(i);
      else if (a[15]) e.data = 8'h00;
      else           e.data = shadow[a[14:0]];
      if (we && !a[15]) shadow[a[14:0]] = e.data;
      sb_q.push_back(e);
    end
    acks = 0; dones = 0; gnt_lat = -1; min_gap = 1000; max_gap = 0; last_ack = -1;
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_len = len; bus.dbg_wdata = wbase;
    for (int c = 0; c < 3000 && dones == 0; c++) begin
      @(negedge clk);
      ack_seen = bus.dbg_ack;
      if (bus.dbg_gnt && gnt_lat < 0) gnt_lat = c;
      if (bus.dbg_ack) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++; $display("FAIL sb_extra_ack: ack with empty scoreboard at addr %h", bus.mem_addr);
        end else begin
          e = sb_q.pop_front();
          if (bus.dbg_err !== e.err) begin
            bad++; $display("FAIL beat_err @%h: got %b want %b", e.addr, bus.dbg_err, e.err);
          end
          if (we) begin
            total++;
            if (bus.mem_we !== !e.err) begin
              bad++; $display("FAIL beat_mem_we @%h: got %b want %b", e.addr, bus.mem_we, !e.err);
            end
            if (!e.err) begin
              total++;
              if ({bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
                bad++; $display("FAIL beat_wr: got %h/%h want %h/%h", bus.mem_addr, bus.mem_wdata, e.addr, e.data);
              end
            end
          end else begin
            total++;
            if (bus.dbg_rdata !== e.data) begin
              bad++; $display("FAIL beat_rdata @%h: got %h want %h", e.addr, bus.dbg_rdata, e.data);
            end
          end
        end
        if (last_ack >= 0) begin
          if (c - last_ack < min_gap) min_gap = c - last_ack;
          if (c - last_ack > max_gap) max_gap = c - last_ack;
        end
        last_ack = c;
        acks++;
      end
      if (bus.dbg_done) dones++;
      @(posedge clk); #1;
      if (ack_seen) bus.dbg_wdata = wbase + 8'(acks);
      if (gnt_lat >= 0 && !hold_req) bus.dbg_req = 1'b0;
    end
    if (!hold_req) bus.dbg_req = 1'b0;
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_missing: %0d beats never acked", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h00; bus.cpu_oe = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_at_boundary = 1'b1;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0000; bus.dbg_len = 8'h00; bus.dbg_wdata = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.cpu_stall, bus.dbg_gnt, bus.dbg_ack, bus.dbg_err, bus.dbg_done} !== 5'b00000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000",
                      {bus.cpu_stall, bus.dbg_gnt, bus.dbg_ack, bus.dbg_err, bus.dbg_done});
    end
    total++;
    if (bus.dbg_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", bus.dbg_rdata); end
    total++;
    if (bus.mem_addr !== 16'h1234) begin bad++; $display("FAIL reset_pass_addr: got %h want 1234", bus.mem_addr); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 4; i++) cpu_write(16'h0010 + 16'(i), 8'hA0 + 8'(i));
    cpu_write(16'h7FFF, 8'h5A);
    cpu_write(16'h0000, 8'h3C);
    @(posedge clk); #1;
    bus.cpu_addr = 16'h0011; bus.cpu_oe = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.mem_oe, bus.mem_addr} !== {1'b1, 16'h0011}) begin
      bad++; $display("FAIL pass_oe: got %b/%h want 1/0011", bus.mem_oe, bus.mem_addr);
    end
    @(negedge clk);
    total++;
    if (bus.cpu_rdata !== 8'hA1) begin bad++; $display("FAIL pass_rdata: got %h want a1", bus.cpu_rdata); end
    @(posedge clk); #1;
    bus.cpu_oe = 1'b0;
  endtask

  task automatic test_single_write();
    int acks, dones, gl, mn, mx;
    run_burst(1'b1, 16'h0002, 8'd0, 8'h25, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if (gl < 1 || gl > 2) begin bad++; $display("FAIL sw_gnt_latency: got %0d want 1..2", gl); end
    total++;
    if ({acks, dones} !== {32'sd1, 32'sd1}) begin bad++; $display("FAIL sw_counts: acks %0d dones %0d want 1 1", acks, dones); end
    run_burst(1'b0, 16'h0002, 8'd0, 8'h00, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if (acks != 1) begin bad++; $display("FAIL sw_readback_acks: got %0d want 1", acks); end
  endtask

  task automatic test_read_burst();
    int acks, dones, gl, mn, mx;
    run_burst(1'b0, 16'h0010, 8'd3, 8'h00, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if ({acks, dones} !== {32'sd4, 32'sd1}) begin bad++; $display("FAIL rb_counts: acks %0d dones %0d want 4 1", acks, dones); end
    total++;
    if (mn != 2 || mx != 2) begin bad++; $display("FAIL rb_spacing: gaps %0d..%0d want 2..2", mn, mx); end
  endtask

  task automatic test_stall_sync();
    int dones;
    bus.cpu_at_boundary = 1'b0;
    @(posedge clk); #1;
    bus.cpu_addr = 16'h0123; bus.cpu_oe = 1'b1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0010; bus.dbg_len = 8'd0;
    @(negedge clk);
    total++;
    if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL ss_stall_early: got %b want 0", bus.cpu_stall); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({bus.cpu_stall, bus.dbg_gnt, bus.mem_oe, bus.mem_addr} !== {3'b101, 16'h0123}) begin
        bad++; $display("FAIL ss_wait%0d: stall/gnt/oe/addr %b%b%b/%h want 101/0123",
                        k, bus.cpu_stall, bus.dbg_gnt, bus.mem_oe, bus.mem_addr);
      end
    end
    @(posedge clk); #1;
    bus.cpu_at_boundary = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.dbg_gnt, bus.mem_addr} !== {1'b1, 16'h0010}) begin
      bad++; $display("FAIL ss_grant: gnt/addr %b/%h want 1/0010", bus.dbg_gnt, bus.mem_addr);
    end
    @(posedge clk); #1;
    bus.dbg_req = 1'b0; bus.cpu_oe = 1'b0;
    dones = 0;
    for (int c = 0; c < 20 && dones == 0; c++) begin
      @(negedge clk);
      if (bus.dbg_ack) begin
        total++;
        if (bus.dbg_rdata !== 8'hA0) begin bad++; $display("FAIL ss_rdata: got %h want a0", bus.dbg_rdata); end
      end
      if (bus.dbg_done) dones++;
    end
    total++;
    if (dones != 1) begin bad++; $display("FAIL ss_done: got %0d want 1", dones); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    int acks, dones, gl, mn, mx;
    run_burst(1'b1, 16'h8000, 8'd0, 8'h77, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if ({acks, dones} !== {32'sd1, 32'sd1}) begin bad++; $display("FAIL oor_wr_counts: acks %0d dones %0d want 1 1", acks, dones); end
    run_burst(1'b0, 16'h7FFF, 8'd1, 8'h00, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if (acks != 2) begin bad++; $display("FAIL oor_rd_acks: got %0d want 2", acks); end
    run_burst(1'b0, 16'hFFFF, 8'd1, 8'h00, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if ({acks, dones} !== {32'sd2, 32'sd1}) begin bad++; $display("FAIL wrap_counts: acks %0d dones %0d want 2 1", acks, dones); end
  endtask

  task automatic test_req_hold();
    int acks, dones, gl, mn, mx;
    run_burst(1'b1, 16'h0300, 8'd1, 8'h40, 1'b1, acks, dones, gl, mn, mx);
    total++;
    if (acks != 2) begin bad++; $display("FAIL hold_acks: got %0d want 2", acks); end
    @(negedge clk);
    total++;
    if ({bus.cpu_stall, bus.dbg_gnt} !== 2'b00) begin bad++; $display("FAIL hold_release: stall/gnt %b%b want 00", bus.cpu_stall, bus.dbg_gnt); end
    @(posedge clk); #1;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.cpu_stall !== 1'b0) begin bad++; $display("FAIL hold_no_restart: stall %b want 0", bus.cpu_stall); end
  endtask

  task automatic test_back_to_back();
    int acks, dones, gl, mn, mx;
    run_burst(1'b1, 16'h0200, 8'd3, 8'hC0, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if (acks != 4) begin bad++; $display("FAIL b2b_wr_acks: got %0d want 4", acks); end
    run_burst(1'b0, 16'h0200, 8'd3, 8'h00, 1'b0, acks, dones, gl, mn, mx);
    total++;
    if ({acks, dones} !== {32'sd4, 32'sd1}) begin bad++; $display("FAIL b2b_rd_counts: acks %0d dones %0d want 4 1", acks, dones); end
  endtask

  task automatic test_reset_mid_burst();
    int acks, dones;
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0100; bus.dbg_len = 8'd7; bus.dbg_wdata = 8'h90;
    acks = 0;
    for (int c = 0; c < 100 && acks < 3; c++) begin
      @(negedge clk);
      if (bus.dbg_ack) acks++;
      if (acks < 3) begin @(posedge clk); #1; end
    end
    total++;
    if (acks != 3) begin bad++; $display("FAIL rmb_reach_beat2: acks %0d want 3", acks); end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({bus.cpu_stall, bus.dbg_gnt, bus.dbg_ack, bus.dbg_err, bus.dbg_done, bus.mem_we, bus.mem_oe, bus.dbg_rdata} !== 15'd0) begin
      bad++; $display("FAIL rmb_outputs: stall/gnt/ack/err/done/we/oe %b rdata %h want 0",
                      {bus.cpu_stall, bus.dbg_gnt, bus.dbg_ack, bus.dbg_err, bus.dbg_done, bus.mem_we, bus.mem_oe}, bus.dbg_rdata);
    end
    bus.dbg_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.dbg_done) dones++;
    end
    total++;
    if (dones != 0) begin bad++; $display("FAIL rmb_no_done: got %0d want 0", dones); end
  endtask

`ifdef ARB_STALL_TIMEOUT_EN
  task automatic test_timeout();
    int stall_cycles, err_at, gnt_seen;
    bus.cpu_at_boundary = 1'b0;
    @(posedge clk); #1;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0010; bus.dbg_len = 8'd0;
    stall_cycles = 0; err_at = -1; gnt_seen = 0;
    for (int c = 0; c < 200 && err_at < 0; c++) begin
      @(negedge clk);
      if (bus.cpu_stall) stall_cycles++;
      if (bus.dbg_gnt) gnt_seen++;
      if (bus.dbg_err) err_at = stall_cycles;
      @(posedge clk); #1;
    end
    bus.dbg_req = 1'b0;
    @(negedge clk);
    total++;
    if (err_at != 64) begin bad++; $display("FAIL to_err_cycle: got %0d want 64", err_at); end
    total++;
    if ({bus.cpu_stall, gnt_seen} !== {1'b0, 32'sd0}) begin
      bad++; $display("FAIL to_release: stall %b gnt_cycles %0d want 0 0", bus.cpu_stall, gnt_seen);
    end
    bus.cpu_at_boundary = 1'b1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_passthrough();
    test_single_write();
    test_read_burst();
    test_stall_sync();
    test_out_of_range();
    test_req_hold();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef ARB_STALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
